// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs the imem req/ack handshake and
// presents one instruction at a time to decode, with delayed-branch redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        flush_valid_i,
  input  logic [31:0] flush_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        addr_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        aerr_q, aerr_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        err_hold_q, err_hold_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  logic        can_issue, capture, misalign, req;
  logic [31:0] addr;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    vld_d       = vld_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    aerr_d      = aerr_q;
    pend_vld_d  = pend_vld_q;
    pend_tgt_d  = pend_tgt_q;
    err_hold_d  = err_hold_q;
    drop_addr_d = drop_addr_q;
    can_issue   = !vld_q || !stall_i;
    capture     = 1'b0;
    misalign    = 1'b0;
    req         = 1'b0;
    addr        = pc_q;

    case (state_q)
      S_IDLE: begin
        if (can_issue && !err_hold_q) begin
          if (pc_q[1:0] == 2'b00) begin
            req = 1'b1;
            if (imem_ack_i) capture = !flush_valid_i;
            else            state_d = flush_valid_i ? S_DROP : S_BUSY;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      S_BUSY: begin
        req = 1'b1;
        if (imem_ack_i) begin
          capture = !flush_valid_i;
          state_d = S_IDLE;
        end else if (flush_valid_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // pc already holds the flush target; finish the abandoned access first
        req  = 1'b1;
        addr = drop_addr_q;
        if (imem_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_DROP) drop_addr_d = pc_q;

    if (vld_q && !stall_i) vld_d = 1'b0;

    if (capture) begin
      vld_d      = 1'b1;
      instr_d    = imem_rdata_i;
      ipc_d      = pc_q;
      aerr_d     = 1'b0;
      pc_d       = pend_vld_q ? pend_tgt_q : pc_q + 32'd4;
      pend_vld_d = 1'b0;
    end

    if (misalign && !flush_valid_i) begin
      vld_d      = 1'b1;
      instr_d    = 32'h0;
      ipc_d      = pc_q;
      aerr_d     = 1'b1;
      err_hold_d = 1'b1;
    end

    // the capture in a redirect cycle is the delay slot, so jump straight away
    if (redirect_valid_i && !flush_valid_i) begin
      if (capture) begin
        pc_d = redirect_target_i;
      end else begin
        pend_vld_d = 1'b1;
        pend_tgt_d = redirect_target_i;
      end
    end

    if (flush_valid_i) begin
      pc_d       = flush_target_i;
      vld_d      = 1'b0;
      pend_vld_d = 1'b0;
      err_hold_d = 1'b0;
      aerr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      vld_q       <= 1'b0;
      instr_q     <= 32'h0;
      ipc_q       <= 32'h0;
      aerr_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_tgt_q  <= 32'h0;
      err_hold_q  <= 1'b0;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      vld_q       <= vld_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
      aerr_q      <= aerr_d;
      pend_vld_q  <= pend_vld_d;
      pend_tgt_q  <= pend_tgt_d;
      err_hold_q  <= err_hold_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  assign imem_req_o    = req && reset_ni;
  assign imem_addr_o   = addr;
  assign instr_valid_o = vld_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign addr_err_o    = aerr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: variable-latency memory model, one script
// of cycles with hand-computed expectations sampled after the falling edge.
module tb_fetch_ctrl;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, rv, fv;
  logic [31:0] rt, ft;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        ivld, aerr;
  logic [31:0] instr, ipc;

  int lat;
  int wait_cnt;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk_i            (clk),
    .reset_ni         (reset_n),
    .stall_i          (stall),
    .redirect_valid_i (rv),
    .redirect_target_i(rt),
    .flush_valid_i    (fv),
    .flush_target_i   (ft),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_ack_i       (imem_ack),
    .imem_rdata_i     (imem_rdata),
    .instr_valid_o    (ivld),
    .instr_o          (instr),
    .instr_pc_o       (ipc),
    .addr_err_o       (aerr)
  );

  // memory acks after lat wait cycles; data is a fixed function of the address
  assign imem_ack   = imem_req && (wait_cnt == lat);
  assign imem_rdata = imem_addr ^ K;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int l, input logic st, input logic r_v, input logic [31:0] r_t,
                     input logic f_v, input logic [31:0] f_t);
    @(negedge clk);
    lat = l; stall = st; rv = r_v; rt = r_t; fv = f_v; ft = f_t;
    #1;
  endtask

  task automatic slot(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".vld"}, {31'b0, ivld}, {31'b0, v});
    if (v) begin
      chk({tag, ".pc"}, ipc, pc);
      chk({tag, ".instr"}, instr, pc ^ K);
    end
  endtask

  task automatic req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, r});
    if (r) chk({tag, ".addr"}, imem_addr, a);
  endtask

  initial begin
    wait_cnt = 0;
    lat = 0; stall = 0; rv = 0; rt = 0; fv = 0; ft = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.req", {31'b0, imem_req}, 32'h0);
    chk("rst.addr", imem_addr, 32'h3000);
    chk("rst.vld", {31'b0, ivld}, 32'h0);
    chk("rst.instr", instr, 32'h0);
    chk("rst.ipc", ipc, 32'h0);
    chk("rst.aerr", {31'b0, aerr}, 32'h0);

    // zero-wait stream from reset
    @(negedge clk); reset_n = 1'b1; #1;
    req("a0", 1, 32'h3000); slot("a0", 0, 0);
    cyc(0, 0, 0, 0, 0, 0); req("a1", 1, 32'h3004); slot("a1", 1, 32'h3000);
    cyc(0, 0, 0, 0, 0, 0); req("a2", 1, 32'h3008); slot("a2", 1, 32'h3004);

    // stall holds slot 0x3008, no requests
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0, 0); req("stall", 0, 0); slot("stall", 1, 32'h3008);
    end
    cyc(0, 0, 0, 0, 0, 0); req("unstall", 1, 32'h300C); slot("unstall", 1, 32'h3008);

    // slow memory, branch at 0x3010 redirects to 0x3100 after delay slot
    cyc(2, 0, 0, 0, 0, 0); req("d0", 1, 32'h3010); slot("d0", 1, 32'h300C);
    cyc(2, 0, 0, 0, 0, 0); req("d1", 1, 32'h3010); slot("d1", 0, 0);
    cyc(2, 0, 0, 0, 0, 0); req("d2", 1, 32'h3010); slot("d2", 0, 0);
    cyc(2, 0, 1, 32'h3100, 0, 0); req("d3", 1, 32'h3014); slot("d3", 1, 32'h3010);
    cyc(2, 0, 0, 0, 0, 0); req("d4", 1, 32'h3014); slot("d4", 0, 0);
    cyc(2, 0, 0, 0, 0, 0); req("d5", 1, 32'h3014);
    cyc(2, 0, 0, 0, 0, 0); req("d6", 1, 32'h3100); slot("d6", 1, 32'h3014);

    // flush while BUSY on 0x3100: access dropped on old address
    cyc(2, 0, 0, 0, 1, 32'h3010); req("f0", 1, 32'h3100); slot("f0", 0, 0);
    cyc(2, 0, 0, 0, 0, 0); req("f1", 1, 32'h3100); slot("f1", 0, 0);
    cyc(0, 0, 0, 0, 0, 0); req("f2", 1, 32'h3010); slot("f2", 0, 0);

    // redirect in the cycle the delay slot is acked
    cyc(0, 0, 1, 32'h3100, 0, 0); req("s0", 1, 32'h3014); slot("s0", 1, 32'h3010);
    cyc(0, 0, 0, 0, 0, 0); req("s1", 1, 32'h3100); slot("s1", 1, 32'h3014);

    // redirect to misaligned 0x3102
    cyc(0, 0, 1, 32'h3102, 0, 0); req("m0", 1, 32'h3104); slot("m0", 1, 32'h3100);
    cyc(0, 0, 0, 0, 0, 0); req("m1", 0, 0); slot("m1", 1, 32'h3104);
    chk("m1.aerr", {31'b0, aerr}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0); req("m2", 0, 0);
    chk("m2.vld", {31'b0, ivld}, 32'h1);
    chk("m2.aerr", {31'b0, aerr}, 32'h1);
    chk("m2.pc", ipc, 32'h3102);
    chk("m2.instr", instr, 32'h0);
    cyc(0, 0, 0, 0, 0, 0); req("m3", 0, 0); slot("m3", 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h4180); req("m4", 0, 0);

    // flush with same-cycle ack discards data; then wrap at 2^32
    cyc(0, 0, 0, 0, 1, 32'h5000); req("w0", 1, 32'h4180); slot("w0", 0, 0);
    chk("w0.aerr", {31'b0, aerr}, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC); req("w1", 1, 32'h5000); slot("w1", 0, 0);
    cyc(0, 0, 0, 0, 0, 0); req("w2", 1, 32'hFFFF_FFFC); slot("w2", 0, 0);
    cyc(0, 0, 0, 0, 0, 0); req("w3", 1, 32'h0); slot("w3", 1, 32'hFFFF_FFFC);

    // reset while a request is outstanding
    cyc(2, 0, 0, 0, 0, 0); req("r0", 1, 32'h4); slot("r0", 1, 32'h0);
    #2 reset_n = 1'b0; #1;
    chk("r1.req", {31'b0, imem_req}, 32'h0);
    chk("r1.addr", imem_addr, 32'h3000);
    chk("r1.vld", {31'b0, ivld}, 32'h0);
    @(negedge clk); lat = 0; reset_n = 1'b1; #1;
    req("r2", 1, 32'h3000);
    cyc(0, 0, 0, 0, 0, 0); req("r3", 1, 32'h3004); slot("r3", 1, 32'h3000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
